// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic GEMM engine: FSM states,
// end-to-end latency and operand extension.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DONE
  } state_t;

  localparam int unsigned EXT_W = 64;

  // Cycles from the accepting edge to the edge that raises out_valid.
  function automatic int unsigned latency(input int unsigned rows,
                                          input int unsigned depth,
                                          input int unsigned cols);
    return rows + depth + cols + 1;
  endfunction

  // Widen a width-bit operand to EXT_W bits, sign- or zero-extending.
  function automatic logic [EXT_W-1:0] extend(input logic [EXT_W-1:0] value,
                                              input int unsigned       width,
                                              input logic              sign);
    logic [EXT_W-1:0] keep;
    logic             msb;
    keep = (width >= EXT_W) ? '1 : ((EXT_W'(1) << width) - EXT_W'(1));
    msb  = |(value & (EXT_W'(1) << (width - 1)));
    return (value & keep) | ((sign && msb) ? ~keep : '0);
  endfunction

endpackage

// File: rtl/systolic_gemm_engine_pe.sv
// Processing element: registered east/south operand forwarding plus a
// clearable, enabled multiply-accumulate that wraps modulo 2^ACC_W.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned ACC_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             clear,
  input  logic             enable,
  input  logic [ACC_W-1:0] a_in,
  input  logic [ACC_W-1:0] b_in,
  output logic [ACC_W-1:0] a_out,
  output logic [ACC_W-1:0] b_out,
  output logic [ACC_W-1:0] acc
);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      a_out <= '0;
      b_out <= '0;
    end else if (enable) begin
      a_out <= a_in;
      b_out <= b_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + a_in * b_in;
    end
  end

endmodule

// File: rtl/systolic_gemm_engine.sv
// Output-stationary systolic GEMM: C = A*B (+ previous C), A flowing east and
// B flowing south through a ROWS x COLS grid of PEs.
module systolic_gemm_engine
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS  = 3,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned COLS  = 3,
  parameter int unsigned IN_W  = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  signed_mode,
  input  logic                                  accumulate,
  input  logic [ROWS-1:0][DEPTH-1:0][IN_W-1:0]  a_in,
  input  logic [DEPTH-1:0][COLS-1:0][IN_W-1:0]  b_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]  c_out,
  output logic                                  busy
);

  // Compute window spans the full skew wavefront plus one trailing cycle,
  // so the result register loads L cycles after acceptance.
  localparam int unsigned LAST  = latency(ROWS, DEPTH, COLS) - 2;
  localparam int unsigned CNT_W = $clog2(LAST + 1);
  localparam int unsigned A_LEN = DEPTH + ROWS - 1;
  localparam int unsigned B_LEN = DEPTH + COLS - 1;

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic             accept, finish;
  logic             load_phase, compute_phase, clear_acc;

  logic [ROWS-1:0][DEPTH-1:0][IN_W-1:0] a_q;
  logic [DEPTH-1:0][COLS-1:0][IN_W-1:0] b_q;
  logic                                 sign_q, accum_q;

  logic [ACC_W-1:0] a_skew [ROWS][A_LEN];
  logic [ACC_W-1:0] b_skew [COLS][B_LEN];
  logic [ACC_W-1:0] a_link [ROWS][COLS+1];
  logic [ACC_W-1:0] b_link [ROWS+1][COLS];
  logic [ACC_W-1:0] acc    [ROWS][COLS];
  logic [ACC_W-1:0] res    [ROWS][COLS];

  assign load_phase    = (state == ST_LOAD);
  assign compute_phase = (state == ST_COMPUTE);
  assign clear_acc     = load_phase && !accum_q;
  assign finish        = compute_phase && (count == CNT_W'(LAST));
  assign out_valid     = (state == ST_DONE);
  assign busy          = load_phase || compute_phase;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_LOAD;
      end
      ST_LOAD:    state_next = ST_COMPUTE;
      ST_COMPUTE: if (finish) state_next = ST_DONE;
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? ST_LOAD : ST_IDLE;
      end
      default:    state_next = ST_IDLE;
    endcase
    accept = in_ready && in_valid;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      accum_q <= 1'b0;
    end else begin
      state <= state_next;
      count <= (compute_phase && !finish) ? count + 1'b1 : '0;
      if (accept) begin
        a_q     <= a_in;
        b_q     <= b_in;
        sign_q  <= signed_mode;
        accum_q <= accumulate;
      end
    end
  end

  // Row i of A enters i cycles late; slots outside the data carry zeros.
  for (genvar i = 0; i < ROWS; i++) begin : g_arow
    for (genvar s = 0; s < A_LEN; s++) begin : g_slot
      logic [ACC_W-1:0] fill, shift_in;
      if (s >= i && s < i + DEPTH) begin : g_data
        assign fill = ACC_W'(extend(EXT_W'(a_q[i][s-i]), IN_W, sign_q));
      end else begin : g_zero
        assign fill = '0;
      end
      if (s == A_LEN - 1) begin : g_tail
        assign shift_in = '0;
      end else begin : g_body
        assign shift_in = a_skew[i][s+1];
      end
      always_ff @(posedge clock) begin
        if (reset)              a_skew[i][s] <= '0;
        else if (load_phase)    a_skew[i][s] <= fill;
        else if (compute_phase) a_skew[i][s] <= shift_in;
      end
    end
    assign a_link[i][0] = a_skew[i][0];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bcol
    for (genvar s = 0; s < B_LEN; s++) begin : g_slot
      logic [ACC_W-1:0] fill, shift_in;
      if (s >= j && s < j + DEPTH) begin : g_data
        assign fill = ACC_W'(extend(EXT_W'(b_q[s-j][j]), IN_W, sign_q));
      end else begin : g_zero
        assign fill = '0;
      end
      if (s == B_LEN - 1) begin : g_tail
        assign shift_in = '0;
      end else begin : g_body
        assign shift_in = b_skew[j][s+1];
      end
      always_ff @(posedge clock) begin
        if (reset)              b_skew[j][s] <= '0;
        else if (load_phase)    b_skew[j][s] <= fill;
        else if (compute_phase) b_skew[j][s] <= shift_in;
      end
    end
    assign b_link[0][j] = b_skew[j][0];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      systolic_pe #(.ACC_W(ACC_W)) u_pe (
        .clock  (clock),
        .reset  (reset),
        .flush  (load_phase),
        .clear  (clear_acc),
        .enable (compute_phase),
        .a_in   (a_link[i][j]),
        .b_in   (b_link[i][j]),
        .a_out  (a_link[i][j+1]),
        .b_out  (b_link[i+1][j]),
        .acc    (acc[i][j])
      );

      always_ff @(posedge clock) begin
        if (reset)       res[i][j] <= '0;
        else if (finish) res[i][j] <= acc[i][j];
      end
      assign c_out[i][j] = res[i][j];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_east_edge
    logic unused_east;
    assign unused_east = ^a_link[i][COLS];
  end
  for (genvar j = 0; j < COLS; j++) begin : g_south_edge
    logic unused_south;
    assign unused_south = ^b_link[ROWS][j];
  end

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// Directed bench for systolic_gemm_engine: default 3x3, a 2x4x3 shape and an
// 8-bit accumulator instance, all against hand-computed results.
module tb_systolic_gemm_engine;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  int   tests = 0;
  int   fails = 0;

  logic                  d_in_valid, d_in_ready, d_signed, d_accum;
  logic                  d_out_valid, d_out_ready, d_busy;
  logic [2:0][2:0][3:0]  d_a, d_b;
  logic [2:0][2:0][15:0] d_c;

  systolic_gemm_engine u_dut (
    .clock(clock), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .signed_mode(d_signed), .accumulate(d_accum), .a_in(d_a), .b_in(d_b),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .c_out(d_c), .busy(d_busy)
  );

  logic                  r_in_valid, r_in_ready, r_signed, r_accum;
  logic                  r_out_valid, r_out_ready, r_busy;
  logic [1:0][3:0][3:0]  r_a;
  logic [3:0][2:0][3:0]  r_b;
  logic [1:0][2:0][15:0] r_c;

  systolic_gemm_engine #(.ROWS(2), .DEPTH(4), .COLS(3)) u_rect (
    .clock(clock), .reset(reset), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .signed_mode(r_signed), .accumulate(r_accum), .a_in(r_a), .b_in(r_b),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .c_out(r_c), .busy(r_busy)
  );

  logic                 n_in_valid, n_in_ready, n_signed, n_accum;
  logic                 n_out_valid, n_out_ready, n_busy;
  logic [2:0][2:0][3:0] n_a, n_b;
  logic [2:0][2:0][7:0] n_c;

  systolic_gemm_engine #(.ACC_W(8)) u_narrow (
    .clock(clock), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .signed_mode(n_signed), .accumulate(n_accum), .a_in(n_a), .b_in(n_b),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .c_out(n_c), .busy(n_busy)
  );

  localparam logic [35:0]  MAT_I   = 36'h100010001;
  localparam logic [35:0]  MAT_SEQ = 36'h987654321;
  localparam logic [143:0] C_SEQ   = 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001;
  localparam logic [143:0] C_I     = 144'h0001_0000_0000_0000_0001_0000_0000_0000_0001;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_default(input string tag, input logic [35:0] a, input logic [35:0] b,
                               input logic sgn, input logic accm);
    d_a = a; d_b = b; d_signed = sgn; d_accum = accm; d_in_valid = 1'b1;
    step();
    check({tag, "_busy"}, 160'(d_busy), 160'(1'b1));
    d_a = ~a; d_b = ~b; d_signed = ~sgn; d_accum = ~accm; d_in_valid = 1'b0;
  endtask

  task automatic wait_default(input string tag, input logic [143:0] exp);
    int n = 0;
    while (!d_out_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 160'(n), 160'(10));
    check({tag, "_c"}, 160'(d_c), 160'(exp));
  endtask

  task automatic release_default(input string tag);
    d_in_valid = 1'b0;
    d_out_ready = 1'b1;
    step();
    d_out_ready = 1'b0;
    check({tag, "_release"}, 160'({d_out_valid, d_in_ready}), 160'(2'b01));
  endtask

  initial begin
    int seen;
    int n;
    reset = 1'b1;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_signed = 1'b0; d_accum = 1'b0; d_a = '0; d_b = '0;
    r_in_valid = 1'b0; r_out_ready = 1'b0; r_signed = 1'b0; r_accum = 1'b0; r_a = '0; r_b = '0;
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_signed = 1'b0; n_accum = 1'b0; n_a = '0; n_b = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_in_ready", 160'(d_in_ready), 160'(1'b1));
    check("rst_out_valid", 160'(d_out_valid), 160'(1'b0));
    check("rst_busy", 160'(d_busy), 160'(1'b0));
    check("rst_c", 160'(d_c), 160'(0));
    step();
    check("idle_in_ready", 160'(d_in_ready), 160'(1'b1));

    // Identity times 1..9, unsigned: result equals B.
    start_default("ident", MAT_I, MAT_SEQ, 1'b0, 1'b0);
    check("ident_in_ready_busy", 160'(d_in_ready), 160'(1'b0));
    wait_default("ident", C_SEQ);
    release_default("ident");

    // All -1 times all 2, signed; in_valid stays high with junk while busy.
    start_default("sgn", 36'hFFFFFFFFF, 36'h222222222, 1'b1, 1'b0);
    d_in_valid = 1'b1;
    wait_default("sgn", {9{16'hFFFA}});
    d_in_valid = 1'b0;
    release_default("sgn");

    start_default("uns", 36'hFFFFFFFFF, 36'h222222222, 1'b0, 1'b0);
    wait_default("uns", {9{16'd90}});
    release_default("uns");

    // Back-pressure in DONE, then back-to-back acceptance.
    start_default("hold", MAT_I, MAT_SEQ, 1'b0, 1'b0);
    wait_default("hold", C_SEQ);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_c", 160'(d_c), 160'(C_SEQ));
      check("hold_in_ready", 160'(d_in_ready), 160'(1'b0));
    end
    d_a = 36'h111111111; d_b = 36'h111111111; d_signed = 1'b0; d_accum = 1'b0;
    d_in_valid = 1'b1; d_out_ready = 1'b1;
    #1;
    check("chain_in_ready", 160'(d_in_ready), 160'(1'b1));
    step();
    check("chain_load", 160'({d_busy, d_out_valid, d_in_ready}), 160'(3'b100));
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_a = '0; d_b = '0;
    wait_default("chain", {9{16'd3}});
    release_default("chain");

    // Reset while the compute counter reads 4.
    start_default("abort", 36'h111111111, 36'h111111111, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_idle", 160'({d_busy, d_in_ready, d_out_valid}), 160'(3'b010));
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (d_out_valid) seen++;
    end
    check("abort_no_valid", 160'(seen), 160'(0));
    start_default("post", MAT_I, MAT_I, 1'b0, 1'b1);
    wait_default("post", C_I);
    release_default("post");

    // 2x4x3 with all ones times all threes, then accumulate the same set.
    for (int pass = 0; pass < 2; pass++) begin
      r_a = 32'h11111111; r_b = 48'h333333333333; r_accum = (pass == 1); r_in_valid = 1'b1;
      step();
      r_in_valid = 1'b0; r_a = '0; r_b = '0; r_accum = 1'b0;
      n = 0;
      while (!r_out_valid && n < 40) begin
        step();
        n++;
      end
      check("rect_latency", 160'(n), 160'(10));
      check(pass == 0 ? "rect_c" : "rect_acc_c", 160'(r_c),
            pass == 0 ? 160'({6{16'd12}}) : 160'({6{16'd24}}));
      r_out_ready = 1'b1;
      step();
      r_out_ready = 1'b0;
    end

    // 8-bit accumulator wraps: 3 * 15 * 15 = 675 -> 0xA3.
    n_a = 36'hFFFFFFFFF; n_b = 36'hFFFFFFFFF; n_in_valid = 1'b1;
    step();
    n_in_valid = 1'b0; n_a = '0; n_b = '0;
    n = 0;
    while (!n_out_valid && n < 40) begin
      step();
      n++;
    end
    check("narrow_latency", 160'(n), 160'(10));
    check("narrow_c", 160'(n_c), 160'({9{8'hA3}}));
    n_out_ready = 1'b1;
    step();
    n_out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
